// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package dmem_pkg;

    localparam int DATA_WIDTH = 32;

    // RISC-V funct3 access sizes
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } size_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/dmem_align.sv
// Request-side error/byte-enable/store replication and response-side lane select/extend.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  req_off_i,
    input  logic [2:0]  req_size_i,
    input  logic        req_we_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_err_o,
    output logic [3:0]  req_be_o,
    output logic [31:0] req_wdata_o,
    input  logic [1:0]  rsp_off_i,
    input  logic [2:0]  rsp_size_i,
    input  logic [31:0] rsp_word_i,
    output logic [31:0] rsp_rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        req_err_o = 1'b0;
        case (req_size_i)
            LB:       req_err_o = 1'b0;
            LH, LHU:  req_err_o = req_off_i[0];
            LW:       req_err_o = |req_off_i;
            LBU:      req_err_o = 1'b0;
            default:  req_err_o = 1'b1;
        endcase
        // unsigned sizes are load-only
        if (req_we_i && (req_size_i == LBU || req_size_i == LHU)) begin
            req_err_o = 1'b1;
        end
    end

    always_comb begin
        req_be_o    = 4'b0000;
        req_wdata_o = req_wdata_i;
        case (req_size_i)
            LB: begin
                req_be_o    = 4'b0001 << req_off_i;
                req_wdata_o = {4{req_wdata_i[7:0]}};
            end
            LH: begin
                req_be_o    = req_off_i[1] ? 4'b1100 : 4'b0011;
                req_wdata_o = {2{req_wdata_i[15:0]}};
            end
            LW:      req_be_o = 4'b1111;
            default: req_be_o = 4'b0000;
        endcase
        if (!req_we_i || req_err_o) begin
            req_be_o = 4'b0000;
        end
    end

    always_comb begin
        case (rsp_off_i)
            2'd0:    byte_sel = rsp_word_i[7:0];
            2'd1:    byte_sel = rsp_word_i[15:8];
            2'd2:    byte_sel = rsp_word_i[23:16];
            default: byte_sel = rsp_word_i[31:24];
        endcase
        half_sel = rsp_off_i[1] ? rsp_word_i[31:16] : rsp_word_i[15:0];
        case (rsp_size_i)
            LB:      rsp_rdata_o = {{24{byte_sel[7]}}, byte_sel};
            LBU:     rsp_rdata_o = {24'h0, byte_sel};
            LH:      rsp_rdata_o = {{16{half_sel[15]}}, half_sel};
            LHU:     rsp_rdata_o = {16'h0, half_sel};
            LW:      rsp_rdata_o = rsp_word_i;
            default: rsp_rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Single-port data memory with valid/ready request and one-deep registered response.
// State table: ST_EMPTY | no response held ; ST_FULL | response valid, waiting for consume
module dmem_lsu #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [2:0]            req_size_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);
    import dmem_pkg::*;

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("dmem_lsu: DATA_WIDTH must be 32");
    end

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    logic [31:0]           mem_q [DEPTH];
    logic [31:0]           word_q;
    rsp_state_e            state_q;
    logic                  err_q;
    logic                  load_ok_q;
    logic [1:0]            off_q;
    logic [2:0]            size_q;

    logic                  accept;
    logic                  consume;
    logic [ADDR_WIDTH-3:0] widx;
    logic                  req_err;
    logic [3:0]            req_be;
    logic [31:0]           req_wdata_rep;
    logic [31:0]           rsp_ext;

    assign widx        = req_addr_i[ADDR_WIDTH-1:2];
    assign req_ready_o = !rst_i && (state_q == ST_EMPTY || rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign consume     = (state_q == ST_FULL) && rsp_ready_i;
    assign rsp_valid_o = (state_q == ST_FULL);
    assign rsp_err_o   = err_q;
    assign rsp_rdata_o = load_ok_q ? rsp_ext : 32'h0;

    dmem_align u_align (
        .req_off_i   (req_addr_i[1:0]),
        .req_size_i  (req_size_i),
        .req_we_i    (req_we_i),
        .req_wdata_i (req_wdata_i),
        .req_err_o   (req_err),
        .req_be_o    (req_be),
        .req_wdata_o (req_wdata_rep),
        .rsp_off_i   (off_q),
        .rsp_size_i  (size_q),
        .rsp_word_i  (word_q),
        .rsp_rdata_o (rsp_ext)
    );

    // Storage has no reset so it maps onto byte-enabled block RAM.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int l = 0; l < 4; l++) begin
                if (req_be[l]) begin
                    mem_q[widx][8*l +: 8] <= req_wdata_rep[8*l +: 8];
                end
            end
            word_q <= mem_q[widx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_EMPTY;
            err_q     <= 1'b0;
            load_ok_q <= 1'b0;
            off_q     <= 2'b00;
            size_q    <= 3'b000;
        end else if (accept) begin
            state_q   <= ST_FULL;
            err_q     <= req_err;
            load_ok_q <= !req_we_i && !req_err;
            off_q     <= req_addr_i[1:0];
            size_q    <= req_size_i;
        end else if (consume) begin
            state_q   <= ST_EMPTY;
        end
    end

endmodule
